// File: rtl/pcm_fifo_sequencer.sv
// Record/playback sequencer that is the sole master of the sample FIFO's clr/wr/rd strobes.
// Latency: sample_tick -> fifo_wr/fifo_rd 1 cycle; fifo_rd -> pcm_valid 2 cycles; all outputs registered.
// Backpressure: fifo_full/word_count==DEPTH ends recording (sticky overflow); fifo_empty/word_count==0 ends playback.
module pcm_fifo_sequencer #(
    parameter int DBITS = 8,
    parameter int CBITS = 10,
    parameter int DEPTH = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rec_start,
    input  logic             play_start,
    input  logic             stop,
    input  logic             sample_tick,
    input  logic [DBITS-1:0] mic_data,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             fifo_clr,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic [DBITS-1:0] fifo_din,
    output logic [DBITS-1:0] pcm_out,
    output logic             pcm_valid,
    output logic [CBITS-1:0] word_count,
    output logic [1:0]       state,
    output logic             overflow,
    output logic             play_done
);

    localparam logic [CBITS-1:0] DEPTH_C = CBITS'(DEPTH);
    localparam logic [CBITS-1:0] ONE_C   = CBITS'(1);

    // S_RD is the cycle fifo_rd is high; S_WAIT is the cycle fifo_dout is valid.
    // Both, like S_CLR, are reported externally as 2'b11.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_REC,
        S_PLAY,
        S_RD,
        S_WAIT
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic             clr_q, clr_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [DBITS-1:0] din_q, din_d;
    logic [DBITS-1:0] pcm_q, pcm_d;
    logic             pvld_q, pvld_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             stop_pend_q, stop_pend_d;

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next state, FIFO strobes and bookkeeping; stop outranks rec_start, play_start, then sample_tick.
    always_comb begin
        fsm_d       = fsm_q;
        clr_d       = 1'b0;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        din_d       = din_q;
        pcm_d       = pcm_q;
        pvld_d      = 1'b0;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        state_d     = 2'b00;

        case (fsm_q)
            S_IDLE: begin
                if (stop) begin
                    fsm_d = S_IDLE;
                end else if (rec_start) begin
                    fsm_d = S_CLR;
                    clr_d = 1'b1;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (play_start && (cnt_q != '0) && !fifo_empty) begin
                    fsm_d = S_PLAY;
                end
            end
            S_CLR: begin
                // Any tick here is dropped; the clear must land before the first write.
                fsm_d = stop ? S_IDLE : S_REC;
            end
            S_REC: begin
                if (stop) begin
                    fsm_d = S_IDLE;
                end else if (sample_tick) begin
                    if (!fifo_full && (cnt_q < DEPTH_C)) begin
                        wr_d  = 1'b1;
                        din_d = mic_data;
                        cnt_d = cnt_q + ONE_C;
                    end else begin
                        ovf_d = 1'b1;
                        fsm_d = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    fsm_d = S_IDLE;
                end else if (sample_tick) begin
                    // The FIFO's own empty flag wins over our count if they disagree.
                    if (!fifo_empty && (cnt_q != '0)) begin
                        rd_d        = 1'b1;
                        cnt_d       = cnt_q - ONE_C;
                        stop_pend_d = 1'b0;
                        fsm_d       = S_RD;
                    end else begin
                        done_d = 1'b1;
                        fsm_d  = S_IDLE;
                    end
                end
            end
            S_RD: begin
                // A stop here is remembered so the sample in flight still completes.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                fsm_d = S_WAIT;
            end
            S_WAIT: begin
                pcm_d       = fifo_dout;
                pvld_d      = 1'b1;
                stop_pend_d = 1'b0;
                fsm_d       = (stop || stop_pend_q) ? S_IDLE : S_PLAY;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        case (fsm_d)
            S_REC:                 state_d = 2'b01;
            S_PLAY:                state_d = 2'b10;
            S_CLR, S_RD, S_WAIT:   state_d = 2'b11;
            default:               state_d = 2'b00;
        endcase
    end

    // Output and bookkeeping registers; every output comes straight from one of these.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_q       <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            din_q       <= '0;
            pcm_q       <= '0;
            pvld_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= 2'b00;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            clr_q       <= clr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            din_q       <= din_d;
            pcm_q       <= pcm_d;
            pvld_q      <= pvld_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign fifo_clr   = clr_q;
    assign fifo_wr    = wr_q;
    assign fifo_rd    = rd_q;
    assign fifo_din   = din_q;
    assign pcm_out    = pcm_q;
    assign pcm_valid  = pvld_q;
    assign word_count = cnt_q;
    assign state      = state_q;
    assign overflow   = ovf_q;
    assign play_done  = done_q;

endmodule

// File: tb/tb_pcm_fifo_sequencer.sv
// Bench for pcm_fifo_sequencer: table of directed steps, hand-timed corner cases, random events vs a mode-level model.
// A queue-based FIFO stands in for the real sample FIFO; flags can be forced to create full/inconsistent conditions.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_pcm_fifo_sequencer;

    localparam int DB   = 8;
    localparam int CB   = 10;
    localparam int DP   = 4;
    localparam int FCAP = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, sample_tick = 1'b0;
    logic [DB-1:0] mic_data = '0;
    logic          fifo_full, fifo_empty;
    logic [DB-1:0] fifo_dout = '0;
    logic          fifo_clr, fifo_wr, fifo_rd, pcm_valid, overflow, play_done;
    logic [DB-1:0] fifo_din, pcm_out;
    logic [CB-1:0] word_count;
    logic [1:0]    state;

    logic          force_full = 1'b0, force_empty = 1'b0;
    logic          full_m = 1'b0, empty_m = 1'b1;
    logic [DB-1:0] fq[$];

    int total = 0, bad = 0;
    int n_wr = 0, n_rd = 0, n_clr = 0, n_pv = 0, n_pd = 0;
    int b_wr, b_pv, b_pd, b_clr;
    logic [DB-1:0] last_din = '0;
    logic prev_any = 1'b0;

    assign fifo_full  = force_full | full_m;
    assign fifo_empty = force_empty | empty_m;

    pcm_fifo_sequencer #(.DBITS(DB), .CBITS(CB), .DEPTH(DP)) dut (
        .clock(clock), .reset(reset), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .sample_tick(sample_tick), .mic_data(mic_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_clr(fifo_clr), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
        .pcm_out(pcm_out), .pcm_valid(pcm_valid), .word_count(word_count),
        .state(state), .overflow(overflow), .play_done(play_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural sample FIFO: clear, write, read with data valid the cycle after fifo_rd.
    always @(posedge clock) begin
        if (fifo_clr) fq.delete();
        else if (fifo_wr) begin
            if (fq.size() < FCAP) fq.push_back(fifo_din);
        end else if (fifo_rd) begin
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
        end
        full_m  <= (fq.size() >= FCAP);
        empty_m <= (fq.size() == 0);
    end

    // Strobe monitor: pulse counts plus exclusivity and no-back-to-back checks.
    always @(negedge clock) begin
        logic any;
        if (fifo_wr) begin n_wr++; last_din = fifo_din; end
        if (fifo_rd) n_rd++;
        if (fifo_clr) n_clr++;
        if (pcm_valid) n_pv++;
        if (play_done) n_pd++;
        any = fifo_wr | fifo_rd | fifo_clr;
        if (any) begin
            chk("strobe_excl", 32'($countones({fifo_wr, fifo_rd, fifo_clr})), 32'd1);
            chk("strobe_gap", 32'(prev_any), 32'd0);
        end
        prev_any = any;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        b_wr = n_wr; b_pv = n_pv; b_pd = n_pd; b_clr = n_clr;
    endtask

    task automatic apply(input logic r, input logic p, input logic s, input logic t,
                         input logic [DB-1:0] m, input int settle);
        @(negedge clock);
        rec_start = r; play_start = p; stop = s; sample_tick = t; mic_data = m;
        @(negedge clock);
        rec_start = 0; play_start = 0; stop = 0; sample_tick = 0;
        repeat (settle) @(negedge clock);
    endtask

    task automatic check_row(input string nm, input logic [1:0] es, input int ec, input logic eo,
                             input logic [DB-1:0] ep, input int ewr, input int epv, input int epd,
                             input int eclr, input logic [DB-1:0] ed);
        chk({nm, ".state"}, 32'(state), 32'(es));
        chk({nm, ".word_count"}, 32'(word_count), ec);
        chk({nm, ".overflow"}, 32'(overflow), 32'(eo));
        chk({nm, ".pcm_out"}, 32'(pcm_out), 32'(ep));
        chk({nm, ".n_wr"}, n_wr - b_wr, ewr);
        chk({nm, ".n_pcm_valid"}, n_pv - b_pv, epv);
        chk({nm, ".n_play_done"}, n_pd - b_pd, epd);
        chk({nm, ".n_clr"}, n_clr - b_clr, eclr);
        if (ewr > 0) chk({nm, ".fifo_din"}, 32'(last_din), 32'(ed));
    endtask

    typedef struct {
        logic r, p, s, t;
        logic [DB-1:0] mic;
        logic [1:0] es;
        int ec;
        logic eo;
        logic [DB-1:0] ep;
        int ewr, epv, epd, eclr;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic p, input logic s, input logic t, input logic [DB-1:0] mic,
                       input logic [1:0] es, input int ec, input logic eo, input logic [DB-1:0] ep,
                       input int ewr, input int epv, input int epd, input int eclr);
        vec_t v;
        v.r = r; v.p = p; v.s = s; v.t = t; v.mic = mic; v.es = es; v.ec = ec; v.eo = eo;
        v.ep = ep; v.ewr = ewr; v.epv = epv; v.epd = epd; v.eclr = eclr;
        tbl.push_back(v);
    endtask

    // Mode-level reference model state for the random phase.
    int            m_st, m_cnt;
    logic          m_ovf;
    logic [DB-1:0] m_pcm;
    logic [DB-1:0] m_fifo[$];

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst.state", 32'(state), 0);
        chk("rst.word_count", 32'(word_count), 0);
        chk("rst.strobes", 32'({fifo_clr, fifo_wr, fifo_rd, pcm_valid, play_done, overflow}), 0);
        chk("rst.data", 32'({pcm_out, fifo_din}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // ---- directed table (DEPTH = 4) ----
        //   r p s t  mic    st cnt ovf pcm   wr pv pd clr
        row(0,1,0,0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0); // play with nothing recorded: ignored
        row(1,0,0,0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 1);
        row(0,0,0,1, 8'h11, 1, 1, 0, 8'h00, 1, 0, 0, 0);
        row(0,0,0,1, 8'h22, 1, 2, 0, 8'h00, 1, 0, 0, 0);
        row(0,0,0,1, 8'h33, 1, 3, 0, 8'h00, 1, 0, 0, 0);
        row(0,0,1,0, 8'h00, 0, 3, 0, 8'h00, 0, 0, 0, 0);
        row(0,1,0,0, 8'h00, 2, 3, 0, 8'h00, 0, 0, 0, 0);
        row(0,0,0,1, 8'h00, 2, 2, 0, 8'h11, 0, 1, 0, 0);
        row(0,0,0,1, 8'h00, 2, 1, 0, 8'h22, 0, 1, 0, 0);
        row(0,0,0,1, 8'h00, 2, 0, 0, 8'h33, 0, 1, 0, 0);
        row(0,0,0,1, 8'h00, 0, 0, 0, 8'h33, 0, 0, 1, 0); // drained: play_done
        row(1,1,0,0, 8'h00, 1, 0, 0, 8'h33, 0, 0, 0, 1); // rec_start beats play_start
        row(0,0,0,1, 8'ha1, 1, 1, 0, 8'h33, 1, 0, 0, 0);
        row(1,0,0,0, 8'h00, 1, 1, 0, 8'h33, 0, 0, 0, 0); // rec_start ignored while recording
        row(0,1,0,0, 8'h00, 1, 1, 0, 8'h33, 0, 0, 0, 0); // play_start ignored while recording
        row(0,0,0,1, 8'ha2, 1, 2, 0, 8'h33, 1, 0, 0, 0);
        row(0,0,0,1, 8'ha3, 1, 3, 0, 8'h33, 1, 0, 0, 0);
        row(0,0,0,1, 8'ha4, 1, 4, 0, 8'h33, 1, 0, 0, 0);
        row(0,0,0,1, 8'ha5, 0, 4, 1, 8'h33, 0, 0, 0, 0); // count at DEPTH: overflow
        row(0,0,0,1, 8'ha6, 0, 4, 1, 8'h33, 0, 0, 0, 0); // tick in IDLE ignored
        row(1,0,1,0, 8'h00, 0, 4, 1, 8'h33, 0, 0, 0, 0); // stop beats rec_start
        row(0,1,0,0, 8'h00, 2, 4, 1, 8'h33, 0, 0, 0, 0);
        row(0,0,1,1, 8'h00, 0, 4, 1, 8'h33, 0, 0, 0, 0); // stop with tick in PLAY: no read
        for (int i = 0; i < tbl.size(); i++) begin
            snap();
            apply(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].t, tbl[i].mic, 5);
            check_row($sformatf("row%0d", i), tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ep,
                      tbl[i].ewr, tbl[i].epv, tbl[i].epd, tbl[i].eclr, tbl[i].mic);
        end

        // ---- stop during WAIT: sample still completes ----
        apply(0, 1, 0, 0, 8'h00, 5);
        snap();
        apply(0, 0, 0, 1, 8'h00, 0);
        apply(0, 0, 1, 0, 8'h00, 5);
        check_row("stop_wait", 2'd0, 3, 1'b1, 8'ha1, 0, 1, 0, 0, 8'h00);

        // ---- stop during the fifo_rd cycle, with cycle-exact latency checks ----
        apply(0, 1, 0, 0, 8'h00, 5);
        snap();
        @(negedge clock); sample_tick = 1;
        @(negedge clock); sample_tick = 0;
        chk("rd_cyc.fifo_rd", 32'(fifo_rd), 1);
        chk("rd_cyc.state", 32'(state), 3);
        stop = 1;
        @(negedge clock); stop = 0;
        chk("wait_cyc.state", 32'(state), 3);
        chk("wait_cyc.pcm_valid", 32'(pcm_valid), 0);
        @(negedge clock);
        chk("pv_cyc.pcm_valid", 32'(pcm_valid), 1);
        chk("pv_cyc.pcm_out", 32'(pcm_out), 32'h a2);
        chk("pv_cyc.state", 32'(state), 0);
        repeat (4) @(negedge clock);
        check_row("stop_rd", 2'd0, 2, 1'b1, 8'ha2, 0, 1, 0, 0, 8'h00);

        // ---- FIFO reports empty while count is non-zero: flag wins ----
        apply(0, 1, 0, 0, 8'h00, 5);
        force_empty = 1'b1;
        snap();
        apply(0, 0, 0, 1, 8'h00, 5);
        check_row("flag_empty", 2'd0, 2, 1'b1, 8'ha2, 0, 0, 1, 0, 8'h00);
        force_empty = 1'b0;

        // ---- stop coincident with tick while recording ----
        apply(1, 0, 0, 0, 8'h00, 5);
        snap();
        apply(0, 0, 1, 1, 8'h77, 5);
        check_row("stop_tick_rec", 2'd0, 0, 1'b0, 8'ha2, 0, 0, 0, 0, 8'h00);

        // ---- async reset between fifo_rd and WAIT ----
        apply(1, 0, 0, 0, 8'h00, 5);
        apply(0, 0, 0, 1, 8'h5a, 5);
        apply(0, 0, 1, 0, 8'h00, 5);
        apply(0, 1, 0, 0, 8'h00, 5);
        snap();
        @(negedge clock); sample_tick = 1;
        @(negedge clock); sample_tick = 0;
        chk("arst.pre_rd", 32'(fifo_rd), 1);
        #1 reset = 1'b1;
        #1;
        chk("arst.fifo_rd", 32'(fifo_rd), 0);
        chk("arst.state", 32'(state), 0);
        chk("arst.word_count", 32'(word_count), 0);
        chk("arst.pcm_out", 32'(pcm_out), 0);
        chk("arst.fifo_din", 32'(fifo_din), 0);
        chk("arst.flags", 32'({fifo_clr, fifo_wr, pcm_valid, play_done, overflow}), 0);
        repeat (4) @(negedge clock);
        chk("arst.n_pcm_valid", n_pv - b_pv, 0);
        chk("arst.state_hold", 32'(state), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // ---- random events against the mode-level model ----
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        m_st = 0; m_cnt = 0; m_ovf = 1'b0; m_pcm = '0; m_fifo = fq;
        for (int ev = 0; ev < 250; ev++) begin
            int k;
            logic [DB-1:0] m;
            int ewr, epv, epd, eclr;
            logic full_now, empty_now;
            k = $urandom_range(0, 99);
            m = DB'($urandom);
            ewr = 0; epv = 0; epd = 0; eclr = 0;
            full_now  = force_full || (m_fifo.size() >= FCAP);
            empty_now = force_empty || (m_fifo.size() == 0);
            snap();
            if (k < 50) begin
                if (m_st == 1) begin
                    if (!full_now && m_cnt < DP) begin
                        m_fifo.push_back(m); m_cnt++; ewr = 1;
                    end else begin
                        m_ovf = 1'b1; m_st = 0;
                    end
                end else if (m_st == 2) begin
                    if (!empty_now && m_cnt != 0) begin
                        m_pcm = m_fifo.pop_front(); m_cnt--; epv = 1;
                    end else begin
                        epd = 1; m_st = 0;
                    end
                end
                apply(0, 0, 0, 1, m, 5);
            end else if (k < 60) begin
                if (m_st == 0) begin
                    m_st = 1; m_cnt = 0; m_ovf = 1'b0; m_fifo.delete(); eclr = 1;
                end
                apply(1, 0, 0, 0, m, 5);
            end else if (k < 75) begin
                if (m_st == 0 && m_cnt != 0 && !empty_now) m_st = 2;
                apply(0, 1, 0, 0, m, 5);
            end else if (k < 85) begin
                m_st = 0;
                apply(0, 0, 1, 0, m, 5);
            end else if (k < 92) begin
                @(negedge clock); force_full = ~force_full;
                repeat (2) @(negedge clock);
            end else begin
                @(negedge clock); force_empty = ~force_empty;
                repeat (2) @(negedge clock);
            end
            check_row($sformatf("rnd%0d", ev), 2'(m_st), m_cnt, m_ovf, m_pcm, ewr, epv, epd, eclr, m);
        end
        force_full = 1'b0;
        force_empty = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcm_fifo_sequencer.md
Name: pcm_fifo_sequencer

Overview:
Record/playback controller for the PCM microphone audio path. It sequences the sample FIFO. In record, it writes one microphone sample per sample_tick. In playback, it reads one sample per sample_tick and presents it to the PCM output stage. It is the only master of the FIFO's wr/rd/clear inputs and guarantees wr and rd are never asserted together.

Parameters:
DBITS, 8, sample width in bits
CBITS, 10, width of the internal word counter
DEPTH, 1023, maximum words the controller will write before treating the FIFO as full (must be < 2**CBITS)

Ports:
clock  in  1  system clock
reset  in  1  reset reset, asynchronous, active-high; clock clock
rec_start  in  1  one-cycle pulse (pre-debounced): clear FIFO and begin recording
play_start  in  1  one-cycle pulse: begin playback
stop  in  1  one-cycle pulse: return to IDLE
sample_tick  in  1  one-cycle strobe at audio sample rate; minimum spacing 4 clocks
mic_data  in  DBITS  current microphone sample
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  DBITS  FIFO read data, valid the cycle after fifo_rd
fifo_clr  out  1  one-cycle FIFO clear pulse
fifo_wr  out  1  one-cycle FIFO write pulse
fifo_rd  out  1  one-cycle FIFO read pulse
fifo_din  out  DBITS  FIFO write data
pcm_out  out  DBITS  last sample played, held between samples
pcm_valid  out  1  one-cycle pulse when pcm_out updates
word_count  out  CBITS  words currently held in FIFO per controller bookkeeping
state  out  2  00 IDLE, 01 REC, 10 PLAY, 11 CLR/WAIT (see below)
overflow  out  1  sticky: record stopped because FIFO full
play_done  out  1  one-cycle pulse when playback ends on empty

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; word_count 0; overflow 0; pcm_out 0.
- Reset mid-operation aborts immediately. No further FIFO strobes are issued.
- Input priority in every state: stop > rec_start > play_start > sample_tick.
- IDLE:
  - rec_start -> CLR. fifo_clr=1 for exactly 1 cycle, word_count<=0, overflow<=0.
  - play_start with word_count!=0 and fifo_empty=0 -> PLAY.
  - play_start otherwise is ignored and the block stays in IDLE.
  - sample_tick is ignored.
- CLR (state=11): lasts 1 cycle, then -> REC. A sample_tick arriving in CLR is dropped.
- REC, on sample_tick:
  - If fifo_full=0 and word_count<DEPTH: fifo_wr=1 in the next cycle, fifo_din<=mic_data captured at the tick edge, word_count+1.
  - Else: no write, overflow<=1, -> IDLE.
- REC: stop -> IDLE with no write, even if coincident with sample_tick. rec_start and play_start are ignored.
- PLAY, on sample_tick:
  - If fifo_empty=0 and word_count!=0: fifo_rd=1 in the next cycle, word_count-1, -> WAIT.
  - Else: play_done=1 for 1 cycle, -> IDLE.
- WAIT (state=11): exactly 1 cycle after fifo_rd. pcm_out<=fifo_dout, pcm_valid=1.
  - Then -> PLAY, or -> IDLE if stop arrived during the fifo_rd or WAIT cycle. The sample in flight is always completed.
- PLAY: rec_start and play_start are ignored.
- Latency: sample_tick edge to fifo_wr/fifo_rd assertion is 1 cycle. fifo_rd to pcm_valid is 2 cycles.
- Strobes: fifo_wr, fifo_rd and fifo_clr are mutually exclusive, single-cycle, and never asserted on consecutive cycles.
- word_count never wraps: it saturates at 0 and DEPTH.
- Inconsistent flags: if fifo_empty=1 while word_count!=0, the FIFO flag wins, so playback ends with play_done.

Test Plan:
- Basic record: reset, rec_start, 3 ticks with mic_data 0x11,0x22,0x33 -> fifo_clr one pulse, then fifo_wr 3 pulses with fifo_din 0x11,0x22,0x33, word_count=3, state=01.
- Playback: continue the previous test with stop, play_start, 4 ticks, FIFO model returning 0x11,0x22,0x33 -> pcm_valid 3 pulses, pcm_out 0x11,0x22,0x33, 4th tick gives play_done=1, state=00, word_count=0.
- Overflow: DEPTH=4, rec_start, 6 ticks -> exactly 4 fifo_wr, overflow=1 after 5th tick, state=00, 6th tick ignored.
- Simultaneous events: stop coincident with tick in REC -> no fifo_wr. stop during WAIT -> pcm_valid still pulses once, then IDLE. play_start in IDLE with word_count=0 -> no state change.
- Async reset mid-PLAY between fifo_rd and WAIT -> all outputs 0 immediately, no pcm_valid, state=00.
- Protocol check throughout: fifo_wr&fifo_rd never 1; no strobe high 2 consecutive cycles.
